// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   DATA_W_DEF - default data word width
//   WAIT_CNT_W - width of the wait-state counter (bounds WAIT_STATES to 0..15)
//   state_t    - responder FSM states
//   op_t       - latched request kind
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } op_t;

endpackage : dmem_pkg

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Load/store bus between the core (master) and the data-memory responder (slave).
//   read_en, write_en  strobes, held by the master until ack
//   address            32-bit word address
//   write_data         store data
//   read_data          registered load result
//   ack                one-cycle completion pulse
//   busy               request in flight
//   range_err          out-of-range access flag, valid with ack
//                      (only with DMEM_RANGE_CHECK_EN defined)
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
   parameter int DATA_W = dmem_pkg::DATA_W_DEF
) ();

   logic              read_en;
   logic              write_en;
   logic [31:0]       address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              ack;
   logic              busy;
`ifdef DMEM_RANGE_CHECK_EN
   logic              range_err;
`endif

   modport master (
      output read_en, write_en, address, write_data,
      input  read_data, ack, busy
`ifdef DMEM_RANGE_CHECK_EN
      , input range_err
`endif
   );

   modport slave (
      input  read_en, write_en, address, write_data,
      output read_data, ack, busy
`ifdef DMEM_RANGE_CHECK_EN
      , output range_err
`endif
   );

endinterface : dmem_responder_if

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous RAM, 2^ADDR_W words of DATA_W bits.
//   clk    clock
//   rst    async active-high reset (clears the read register only)
//   en     access enable
//   we     write enable (with en)
//   addr   word index
//   wdata  write data
//   rdata  registered read data; updated only by reads, held otherwise
// -----------------------------------------------------------------------------
module dmem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the storage array has no reset branch; clearing it would force it
   // into flops instead of RAM, and its contents must survive reset anyway.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder side of the core's data-memory load/store interface. Each request
// is latched in IDLE, held for WAIT_STATES extra cycles, performed, and
// acknowledged with a one-cycle ack. Load data stays put until the next load.
//   CLK    system clock
//   RESET  asynchronous active-high reset
//   bus    dmem_responder_if slave modport (strobes, address, data, ack, busy)
// Optional build macro DMEM_RANGE_CHECK_EN: adds bus.range_err and suppresses
// accesses whose address has any bit set at or above DEPTH_LOG2.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_STATES = 2,
   parameter int DATA_W      = DATA_W_DEF
) (
   input logic             CLK,
   input logic             RESET,
   dmem_responder_if.slave bus
);

   generate
      if (WAIT_STATES < 0 || WAIT_STATES > (1 << WAIT_CNT_W) - 1) begin : g_bad_wait
         $error("dmem_responder: WAIT_STATES must be within 0..15");
      end
      if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 31) begin : g_bad_depth
         $error("dmem_responder: DEPTH_LOG2 must be within 1..31");
      end
   endgenerate

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

   state_t                  state_q, state_d;
   op_t                     op_q, op_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic                    ack_q, ack_d;
   logic                    busy_q, busy_d;
   logic                    mem_en, mem_we;
   logic [DATA_W-1:0]       mem_rdata;
   logic                    addr_hi;

   // Any address bit above the indexed range.
   assign addr_hi = |bus.address[31:DEPTH_LOG2];

`ifdef DMEM_RANGE_CHECK_EN
   logic oob_q, oob_d;             // latched request was out of range
   logic range_err_q, range_err_d;
   logic zero_q, zero_d;           // last completed load was out of range
`else
   // Upper address bits are ignored: addresses alias modulo 2^DEPTH_LOG2.
   logic unused_addr_hi;
   assign unused_addr_hi = addr_hi;
`endif

   // NOTE: every signal gets its default before the case statement, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      mem_en  = 1'b0;
      mem_we  = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      oob_d       = oob_q;
      range_err_d = 1'b0;
      zero_d      = zero_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.write_en || bus.read_en) begin
               // Store wins when both strobes are high.
               op_d    = bus.write_en ? OP_STORE : OP_LOAD;
               addr_d  = bus.address[DEPTH_LOG2-1:0];
               data_d  = bus.write_data;
               cnt_d   = WAIT_LOAD;
               busy_d  = 1'b1;
               state_d = WAIT;
`ifdef DMEM_RANGE_CHECK_EN
               oob_d   = addr_hi;
`endif
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               ack_d   = 1'b1;
               state_d = RESP;
               mem_we  = (op_q == OP_STORE);
`ifdef DMEM_RANGE_CHECK_EN
               mem_en      = !oob_q;
               range_err_d = oob_q;
               if (op_q == OP_LOAD) begin
                  zero_d = oob_q;
               end
`else
               mem_en = 1'b1;
`endif
            end
         end
         RESP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         op_q    <= OP_LOAD;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
         oob_q       <= 1'b0;
         range_err_q <= 1'b0;
         zero_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
`ifdef DMEM_RANGE_CHECK_EN
         oob_q       <= oob_d;
         range_err_q <= range_err_d;
         zero_q      <= zero_d;
`endif
      end
   end

   dmem_array #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (CLK),
      .rst   (RESET),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (addr_q),
      .wdata (data_q),
      .rdata (mem_rdata)
   );

   assign bus.ack  = ack_q;
   assign bus.busy = busy_q;
`ifdef DMEM_RANGE_CHECK_EN
   // The array register keeps its last value; an out-of-range load masks it.
   assign bus.read_data = zero_q ? '0 : mem_rdata;
   assign bus.range_err = range_err_q;
`else
   assign bus.read_data = mem_rdata;
`endif

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Drives two responders (WAIT_STATES=2 and WAIT_STATES=0) through directed
// scenarios and a randomized load/store sequence, comparing against a word
// array model. Also exercises range_err when DMEM_RANGE_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   dmem_responder_if #(.DATA_W(32)) bus2 ();
   dmem_responder_if #(.DATA_W(32)) bus0 ();

   dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2), .DATA_W(32)) dut2 (
      .CLK(CLK), .RESET(RESET), .bus(bus2));
   dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0), .DATA_W(32)) dut0 (
      .CLK(CLK), .RESET(RESET), .bus(bus0));

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: index 0 is the 2-wait DUT, index 1 the 0-wait DUT.
   logic [31:0] mem_m   [2][256];
   bit          mem_v   [2][256];
   logic [31:0] exp_rd  [2];
   bit          rd_known[2];
   logic [31:0] wr_q    [2][$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int s, input bit re, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
      if (s == 0) begin
         bus2.read_en = re; bus2.write_en = we; bus2.address = a; bus2.write_data = d;
      end else begin
         bus0.read_en = re; bus0.write_en = we; bus0.address = a; bus0.write_data = d;
      end
   endtask

   function automatic logic get_ack(input int s);
      return (s == 0) ? bus2.ack : bus0.ack;
   endfunction
   function automatic logic get_busy(input int s);
      return (s == 0) ? bus2.busy : bus0.busy;
   endfunction
   function automatic logic [31:0] get_rd(input int s);
      return (s == 0) ? bus2.read_data : bus0.read_data;
   endfunction
`ifdef DMEM_RANGE_CHECK_EN
   function automatic logic get_rerr(input int s);
      return (s == 0) ? bus2.range_err : bus0.range_err;
   endfunction
`endif

   function automatic bit is_oob(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
      return (a[31:8] != '0);
`else
      return 1'b0;
`endif
   endfunction

   // Issue one request, hold it until ack, and check latency, busy, read_data.
   task automatic do_req(input int s, input bit re, input bit we,
                         input logic [31:0] a, input logic [31:0] d, input string tag,
                         output logic [31:0] rd_at_ack, output logic rerr_at_ack);
      int  wait_n = (s == 0) ? 2 : 0;
      int  n      = 0;
      int  busy_n = 0;
      bit  got    = 0;
      int  idx    = int'(a[7:0]);
      bit  oob    = is_oob(a);
      rd_at_ack   = 'x;
      rerr_at_ack = 1'b0;
      @(negedge CLK);
      drive(s, re, we, a, d);
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         n++;
         if (get_busy(s)) busy_n++;
         if (get_ack(s)) begin
            got       = 1;
            rd_at_ack = get_rd(s);
`ifdef DMEM_RANGE_CHECK_EN
            rerr_at_ack = get_rerr(s);
`endif
         end
      end
      drive(s, 1'b0, 1'b0, $urandom, $urandom);
      if (we) begin
         if (!oob) begin
            mem_m[s][idx] = d;
            mem_v[s][idx] = 1'b1;
            wr_q[s].push_back({24'h0, a[7:0]});
         end
      end else if (re) begin
         exp_rd[s]   = oob ? 32'h0 : mem_m[s][idx];
         rd_known[s] = oob || mem_v[s][idx];
      end
      check($sformatf("%s ack_latency", tag), n, wait_n + 2);
      check($sformatf("%s busy_cycles", tag), busy_n, wait_n + 2);
      if (rd_known[s]) check($sformatf("%s read_data", tag), rd_at_ack, exp_rd[s]);
`ifdef DMEM_RANGE_CHECK_EN
      check($sformatf("%s range_err", tag), {31'h0, rerr_at_ack}, {31'h0, oob});
`endif
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("%s ack_drop", tag), {31'h0, get_ack(s)}, 32'h0);
      check($sformatf("%s busy_drop", tag), {31'h0, get_busy(s)}, 32'h0);
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         exp_rd[s]   = 32'h0;
         rd_known[s] = 1'b1;
      end
   endtask

   logic [31:0] rd;
   logic        rerr;

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 256; i++) mem_v[s][i] = 1'b0;
         drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      model_reset();

      // Reset state
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      for (int s = 0; s < 2; s++) begin
         check($sformatf("reset ack s%0d", s), {31'h0, get_ack(s)}, 32'h0);
         check($sformatf("reset busy s%0d", s), {31'h0, get_busy(s)}, 32'h0);
         check($sformatf("reset read_data s%0d", s), get_rd(s), 32'h0);
      end
      RESET = 1'b0;

      // Store then load, 2 wait states
      do_req(0, 1'b0, 1'b1, 32'd5, 32'hCAFE_F00D, "store5", rd, rerr);
      check("store5 keeps read_data", rd, 32'h0);
      do_req(0, 1'b1, 1'b0, 32'd5, 32'h0, "load5", rd, rerr);
      check("load5 value", rd, 32'hCAFE_F00D);

      // Zero wait states
      do_req(1, 1'b0, 1'b1, 32'd7, 32'h1234_5678, "w0 store7", rd, rerr);
      do_req(1, 1'b1, 1'b0, 32'd7, 32'h0, "w0 load7", rd, rerr);
      check("w0 load7 value", rd, 32'h1234_5678);

      // Both strobes: store wins, read_data untouched
      do_req(0, 1'b1, 1'b1, 32'd3, 32'hA5A5_A5A5, "both3", rd, rerr);
      check("both3 keeps read_data", rd, 32'hCAFE_F00D);
      do_req(0, 1'b1, 1'b0, 32'd3, 32'h0, "load3", rd, rerr);
      check("load3 value", rd, 32'hA5A5_A5A5);

      // Reset during WAIT aborts the store
      do_req(0, 1'b0, 1'b1, 32'd9, 32'h0000_0001, "store9", rd, rerr);
      @(negedge CLK);
      drive(0, 1'b0, 1'b1, 32'd9, 32'hFFFF_FFFF);
      @(posedge CLK);
      @(negedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      check("mid busy before reset", {31'h0, bus2.busy}, 32'h1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      RESET = 1'b1;
      #1;
      check("mid reset ack", {31'h0, bus2.ack}, 32'h0);
      check("mid reset busy", {31'h0, bus2.busy}, 32'h0);
      model_reset();
      @(negedge CLK);
      RESET = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("post reset no ack", {31'h0, bus2.ack}, 32'h0);
      end
      do_req(0, 1'b1, 1'b0, 32'd9, 32'h0, "load9", rd, rerr);
      check("load9 value", rd, 32'h0000_0001);

`ifndef DMEM_RANGE_CHECK_EN
      // Aliasing: upper address bits ignored
      do_req(0, 1'b0, 1'b1, 32'h105, 32'h0BAD_BEEF, "alias store", rd, rerr);
      do_req(0, 1'b1, 1'b0, 32'h005, 32'h0, "alias load", rd, rerr);
      check("alias value", rd, 32'h0BAD_BEEF);
`else
      // Range check: out-of-range load returns 0, store is dropped
      do_req(0, 1'b0, 1'b1, 32'h000, 32'h1111_2222, "store0", rd, rerr);
      do_req(0, 1'b1, 1'b0, 32'h100, 32'h0, "oob load", rd, rerr);
      check("oob load range_err", {31'h0, rerr}, 32'h1);
      check("oob load value", rd, 32'h0);
      do_req(0, 1'b0, 1'b1, 32'h100, 32'hDEAD_DEAD, "oob store", rd, rerr);
      check("oob store range_err", {31'h0, rerr}, 32'h1);
      do_req(0, 1'b1, 1'b0, 32'h000, 32'h0, "load0", rd, rerr);
      check("load0 unchanged", rd, 32'h1111_2222);
`endif

      // Randomized loads/stores against the model
      for (int k = 0; k < 30; k++) begin
         int          s  = int'($urandom_range(0, 1));
         bit          st = (wr_q[s].size() == 0) || ($urandom_range(0, 1) == 1);
         logic [31:0] a;
         logic [31:0] hi = is_oob(32'h100) ? 32'h0 : ($urandom & 32'hFFFF_FF00);
         if (st) a = {24'h0, 8'($urandom_range(0, 15))} | hi;
         else    a = wr_q[s][$urandom_range(0, wr_q[s].size() - 1)] | hi;
         do_req(s, !st || ($urandom_range(0, 3) == 0), st, a, $urandom,
                $sformatf("rand%0d s%0d", k, s), rd, rerr);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_dmem_responder
